// File: rtl/sbox_share_driver_d3.sv
// Share driver/collector for the 4-share masked Skinny S-box.
// Splits a nibble into Boolean shares, runs the S-box, recombines the result.
module sbox_share_driver_d3 #(
   parameter int LATENCY       = 8,
   parameter int TIMEOUT_SLACK = 3,
   parameter int FRESH_W       = 126
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_data,
   input  logic [11:0]        mask_rand,
   input  logic [FRESH_W-1:0] fresh_rand,
   output logic [3:0]         X_s0,
   output logic [3:0]         X_s1,
   output logic [3:0]         X_s2,
   output logic [3:0]         X_s3,
   output logic [FRESH_W-1:0] Fresh,
   output logic               sbox_rst,
   input  logic               Synch,
   input  logic [3:0]         Y_s0,
   input  logic [3:0]         Y_s1,
   input  logic [3:0]         Y_s2,
   input  logic [3:0]         Y_s3,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_data,
   output logic               busy,
   output logic               err
);

   localparam int LIMIT = LATENCY + TIMEOUT_SLACK;
   localparam int CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIMIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         x0_q, x0_d;
   logic [3:0]         x1_q, x1_d;
   logic [3:0]         x2_q, x2_d;
   logic [3:0]         x3_q, x3_d;
   logic [FRESH_W-1:0] fresh_q, fresh_d;
   logic [3:0]         out_data_q, out_data_d;
   logic               err_q, err_d;
   logic               accept;

   assign accept = in_valid && (state_q == S_IDLE) && !err_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x0_d       = x0_q;
      x1_d       = x1_q;
      x2_d       = x2_q;
      x3_d       = x3_q;
      out_data_d = out_data_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RUN;
               cnt_d   = '0;
               x1_d    = mask_rand[3:0];
               x2_d    = mask_rand[7:4];
               x3_d    = mask_rand[11:8];
               x0_d    = in_data ^ mask_rand[3:0]
                       ^ mask_rand[7:4] ^ mask_rand[11:8];
            end
         end
         S_RUN: begin
            // Synch beats a coincident timeout
            if (Synch && (cnt_q >= LAT_C)) begin
               out_data_d = Y_s0 ^ Y_s1 ^ Y_s2 ^ Y_s3;
               state_d    = S_DONE;
            end else if (Synch) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_q == LIM_C) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
         x0_d = '0;
         x1_d = '0;
         x2_d = '0;
         x3_d = '0;
      end
      fresh_d = (state_d == S_RUN) ? fresh_rand : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         x0_q       <= '0;
         x1_q       <= '0;
         x2_q       <= '0;
         x3_q       <= '0;
         fresh_q    <= '0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x0_q       <= x0_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
         x3_q       <= x3_d;
         fresh_q    <= fresh_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

   // in_ready is forced low while reset is held
   assign in_ready  = rst && (state_q == S_IDLE) && !err_q;
   assign X_s0      = x0_q;
   assign X_s1      = x1_q;
   assign X_s2      = x2_q;
   assign X_s3      = x3_q;
   assign Fresh     = fresh_q;
   assign sbox_rst  = (state_q != S_RUN);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = out_data_q;
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;

endmodule

// File: tb/tb_sbox_share_driver_d3.sv
// Randomized scoreboard bench for sbox_share_driver_d3 with a
// behavioural masked S-box model driving Synch and Y shares.
module tb_sbox_share_driver_d3;

   localparam int LAT = 8;
   localparam int SLK = 3;
   localparam int FW  = 126;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
      4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF
   };

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_data;
   logic [11:0]   mask_rand;
   logic [FW-1:0] fresh_rand;
   logic [3:0]    X_s0, X_s1, X_s2, X_s3;
   logic [FW-1:0] Fresh;
   logic          sbox_rst;
   logic          Synch;
   logic [3:0]    Y_s0, Y_s1, Y_s2, Y_s3;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_data;
   logic          busy;
   logic          err;

   int   errors = 0;
   int   checks = 0;
   logic [3:0] exp_q[$];
   bit   mon_en = 0;
   bit   hold_rdy = 0;
   bit   rdy_all = 0;
   bit   synch_m = 0;
   bit   synch_force = 0;
   int   synch_at = LAT;
   int   sbox_cyc = -1;
   logic [3:0] cur_in = '0;

   sbox_share_driver_d3 #(
      .LATENCY(LAT), .TIMEOUT_SLACK(SLK), .FRESH_W(FW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .mask_rand(mask_rand),
      .fresh_rand(fresh_rand),
      .X_s0(X_s0), .X_s1(X_s1), .X_s2(X_s2), .X_s3(X_s3),
      .Fresh(Fresh), .sbox_rst(sbox_rst), .Synch(Synch),
      .Y_s0(Y_s0), .Y_s1(Y_s1), .Y_s2(Y_s2), .Y_s3(Y_s3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   assign Synch = synch_m | synch_force;

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Masked S-box model: counts cycles since restart release,
   // pulses Synch at synch_at, re-randomizes Y shares every cycle.
   always @(negedge clk) begin
      logic [31:0] r;
      logic [3:0]  yv;
      if (sbox_rst !== 1'b0) sbox_cyc = -1;
      else sbox_cyc = sbox_cyc + 1;
      synch_m = (sbox_cyc == synch_at);
      r  = $urandom;
      yv = SBOX[X_s0 ^ X_s1 ^ X_s2 ^ X_s3];
      Y_s1 = r[3:0];
      Y_s2 = r[7:4];
      Y_s3 = r[11:8];
      Y_s0 = yv ^ r[3:0] ^ r[7:4] ^ r[11:8];
   end

   // Output scoreboard and hold checks
   always @(negedge clk) begin
      static bit pv = 0;
      static bit phs = 0;
      static logic [3:0] pd = '0;
      out_ready = hold_rdy ? 1'b0 :
                  (rdy_all ? 1'b1 : ($urandom_range(0, 3) != 0));
      if (mon_en && rst) begin
         if (pv && !phs) begin
            chk("out_hold_valid", out_valid, 1);
            chk("out_hold_data", out_data, pd);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %0h expected none",
                        out_data);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
            end
         end
         pv  = out_valid;
         pd  = out_data;
         phs = out_valid && out_ready;
      end else begin
         pv = 0;
      end
   end

   // Share stability/recombination and Fresh checks
   always @(negedge clk) begin
      static logic [3:0] xr [4];
      static bit prev_run = 0;
      logic [127:0] t;
      if (mon_en && rst) begin
         if (sbox_rst == 1'b0) begin
            if (!prev_run) begin
               xr[0] = X_s0; xr[1] = X_s1;
               xr[2] = X_s2; xr[3] = X_s3;
               chk("share_xor", X_s0 ^ X_s1 ^ X_s2 ^ X_s3, cur_in);
            end else begin
               chk("share_stable", {X_s0, X_s1, X_s2, X_s3},
                   {xr[0], xr[1], xr[2], xr[3]});
            end
            chk("fresh_run", Fresh, fresh_rand);
         end else begin
            chk("fresh_zero", Fresh, 0);
            if (!busy) chk("share_idle", {X_s0, X_s1, X_s2, X_s3}, 0);
         end
         prev_run = (sbox_rst == 1'b0);
      end else begin
         prev_run = 0;
      end
      t = {$urandom, $urandom, $urandom, $urandom};
      fresh_rand = t[FW-1:0];
   end

   task automatic check_reset_vals(input logic rdy_exp);
      chk("rst_in_ready", in_ready, rdy_exp);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_shares", {X_s0, X_s1, X_s2, X_s3}, 0);
      chk("rst_fresh", Fresh, 0);
      chk("rst_sbox_rst", sbox_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      check_reset_vals(1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_release_in_ready", in_ready, 1);
   endtask

   // Returns at the negedge of the first RUN cycle
   task automatic send(input logic [3:0] d, input bit push);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_wait: in_ready=%0b after %0d cycles",
                  in_ready, n);
      end
      in_valid  = 1'b1;
      in_data   = d;
      mask_rand = 12'($urandom);
      cur_in    = d;
      if (push) exp_q.push_back(SBOX[d]);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [3:0] perm [16];
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      mask_rand = '0;
      repeat (3) @(negedge clk);
      check_reset_vals(1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("init_in_ready", in_ready, 1);
      mon_en = 1;

      // Basic 0x0 with latency check
      rdy_all = 1;
      @(negedge clk);
      send(4'h0, 1);
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("basic_latency", n, LAT + 2);
      chk("basic_data", out_data, 4'hC);
      chk("basic_err", err, 0);
      @(negedge clk);
      chk("basic_roundtrip_ready", in_ready, 1);
      rdy_all = 0;
      drain();

      // Exhaustive with random backpressure, two shuffled passes
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) perm[i] = 4'(i);
         for (int i = 15; i > 0; i--) begin
            int j;
            logic [3:0] t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
         end
         for (int i = 0; i < 16; i++) send(perm[i], 1);
      end
      drain();
      chk("exh_err", err, 0);

      // Held DONE with toggling Y and a spurious Synch
      hold_rdy = 1;
      repeat (2) @(negedge clk);
      send(4'h9, 1);
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reached_done", out_valid, 1);
      for (int i = 0; i < 20; i++) begin
         synch_force = (i == 5);
         @(negedge clk);
      end
      synch_force = 0;
      chk("hold_err", err, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 4'h8);
      hold_rdy = 0;
      drain();

      // Mid-run reset at cnt = 4
      send(4'h7, 1);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.delete();
      check_reset_vals(1'b0);
      rst = 1'b1;
      @(negedge clk);
      send(4'hF, 1);
      drain();
      chk("midrst_err", err, 0);

      // Early Synch at cnt = 5
      synch_at = 5;
      repeat (2) @(negedge clk);
      send(4'h3, 0);
      n = 1;
      while (!err && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("early_err_cycle", n, 5 + 2);
      chk("early_busy", busy, 0);
      for (int i = 0; i < 10; i++) begin
         chk("early_in_ready", in_ready, 0);
         chk("early_out_valid", out_valid, 0);
         @(negedge clk);
      end
      synch_at = LAT;
      do_reset();

      // Missing Synch: timeout at cnt = LAT + SLK
      synch_at = 1000;
      repeat (2) @(negedge clk);
      send(4'h5, 0);
      n = 1;
      while (!err && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_err_cycle", n, LAT + SLK + 2);
      chk("timeout_sbox_rst", sbox_rst, 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_in_ready", in_ready, 0);
      chk("timeout_out_valid", out_valid, 0);
      synch_at = LAT;
      do_reset();

      // Sanity after error recovery
      send(4'hA, 1);
      drain();
      chk("final_err", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sbox_share_driver_d3.md
# sbox_share_driver_d3

Sequential share driver and collector for the 4-share (d = 3) masked Skinny S-box with HPC2 gadgets and clock gating. It accepts an unmasked nibble over a valid/ready handshake and splits it into four Boolean shares. It holds those shares stable while the gadget pipeline runs, streams per-cycle fresh randomness, and waits for the S-box `Synch` pulse. It then recombines the output shares and returns the unmasked result over a second valid/ready handshake. It is the functional-test and evaluation front end that sits on the input and output ports of the masked S-box.

## Interface
- `LATENCY`, default 8: S-box latency in cycles from release of `sbox_rst` to the expected `Synch` pulse.
- `TIMEOUT_SLACK`, default 3: extra cycles tolerated after `LATENCY` before a missing `Synch` is declared an error.
- `FRESH_W`, default 126: fresh-randomness width (6 bits per HPC2 mux, 21 muxes).
- `clk`  in  1  single clock, shared with the S-box.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input nibble valid.
- `in_ready`  out  1  block can accept a nibble.
- `in_data`  in  4  unmasked S-box input.
- `mask_rand`  in  12  three uniform 4-bit masks, sampled on input accept.
- `fresh_rand`  in  FRESH_W  uniform randomness, sampled every cycle.
- `X_s0`…`X_s3`  out  4 each  input shares to the S-box.
- `Fresh`  out  FRESH_W  registered randomness to the S-box.
- `sbox_rst`  out  1  active-high restart of the S-box clock-gating controller.
- `Synch`  in  1  S-box output-register-loaded pulse.
- `Y_s0`…`Y_s3`  in  4 each  output shares from the S-box.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  4  unmasked S-box output.
- `busy`  out  1  high in RUN or DONE.
- `err`  out  1  sticky protocol error flag.

## Operation
- FSM states: IDLE, RUN, DONE. `in_ready` = (state == IDLE) && !err.
- **IDLE → RUN** on `in_valid && in_ready`. On that edge:
  - `X_s1` = `mask_rand[3:0]`, `X_s2` = `mask_rand[7:4]`, `X_s3` = `mask_rand[11:8]`.
  - `X_s0` = `in_data` ^ `X_s1` ^ `X_s2` ^ `X_s3`.
  - Cycle counter `cnt` is cleared to 0.
- **In RUN:**
  - `X_s*` are held constant, bit-stable, for the whole RUN.
  - `Fresh` is loaded from `fresh_rand` every cycle.
  - `sbox_rst` = 0.
  - `cnt` increments by 1 per cycle and saturates at `LATENCY + TIMEOUT_SLACK`.
- **Synch handling in RUN:**
  - `Synch` with `cnt` ≥ `LATENCY`: register `out_data` = `Y_s0` ^ `Y_s1` ^ `Y_s2` ^ `Y_s3`, then go to DONE.
  - `Synch` with `cnt` < `LATENCY` (early): set `err`, go to IDLE.
  - `cnt` == `LATENCY + TIMEOUT_SLACK` with no `Synch` (timeout): set `err`, go to IDLE.
- **In DONE:** `out_valid` = 1 and `out_data` is held stable. On `out_ready`, go to IDLE.
- **Outside RUN:**
  - `sbox_rst` = 1.
  - `Fresh` = 0.
  - `X_s*` are cleared to 0 on entry to IDLE.
- `Synch` is ignored in IDLE and DONE.
- `err` stays set until reset. While `err` = 1, `in_ready` = 0.
- Reset values: state IDLE, `in_ready` 0 during reset and 1 the cycle after, `out_valid` 0, `out_data` 0, `X_s*` 0, `Fresh` 0, `sbox_rst` 1, `busy` 0, `err` 0, `cnt` 0.

## Timing
- Cycle A is the accept edge. From A+1: state RUN, shares valid, `sbox_rst` = 0, `cnt` = 0.
- With a conforming S-box, `Synch` arrives at `cnt` = `LATENCY` (A+1+`LATENCY`). `out_valid` rises one cycle later.
- Minimum round trip, input accept to next `in_ready`, is `LATENCY` + 3 cycles when `out_ready` is held high.
- There is no input/output overlap: one nibble is in flight at a time.
- `out_valid` never drops without `out_ready`, and `out_data` never changes while `out_valid` = 1.
- Simultaneous `Synch` and timeout in the same cycle: `Synch` wins (capture, no error).
- Reset low at any cycle, including mid-RUN and DONE: all outputs take their reset values on the next edge, and any captured result is discarded.

## Test plan
- **Basic 0x0:** reset, `in_data` = 0x0, random masks, S-box model latency 8 → `Synch` at A+9, `out_valid` at A+10 with `out_data` = 0xC, `err` = 0.
- **Exhaustive with backpressure:** all 16 inputs with random `mask_rand`/`fresh_rand` and random `out_ready` backpressure → outputs match the Skinny table C,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F. `X_s*` are constant across each RUN, and `X_s0` ^ `X_s1` ^ `X_s2` ^ `X_s3` equals `in_data`.
- **Early Synch:** force `Synch` at `cnt` = 5 → `err` = 1, return to IDLE, `in_ready` stays 0, `out_valid` never rises.
- **Missing Synch:** suppress `Synch` → `err` sets exactly at `cnt` = 11, state returns to IDLE, `sbox_rst` = 1 the next cycle.
- **Mid-run reset:** assert `rst` = 0 at `cnt` = 4 → next cycle all outputs are at reset values. After release, input 0xF yields `out_data` = 0xF normally.
- **Held DONE:** hold `out_ready` = 0 for 20 cycles in DONE with toggling `Y_s*` and a spurious `Synch` → `out_data` unchanged, no `err`.
